// File: rtl/extensor_pkg.sv
// Shared types and the immediate-extension function used by the extender
// datapath and by decode-side checkers.
package extensor_pkg;

  typedef enum logic [1:0] {
    MODO_SINAL    = 2'b00,
    MODO_ZERO     = 2'b01,
    MODO_SUPERIOR = 2'b10,
    MODO_BYTE     = 2'b11
  } modo_t;

  // Widest result estender() can produce; callers zero-pad into this width.
  localparam int MAX_W  = 64;
  localparam int BYTE_W = 8;

  // Extends the low in_w bits of imediato to out_w bits. Bits at and above
  // out_w in the result are always zero. Both widths are expected to be
  // elaboration constants so the shifts collapse to wiring.
  function automatic logic [MAX_W-1:0] estender(
    input logic [MAX_W-1:0] imediato,
    input modo_t            modo,
    input int               in_w,
    input int               out_w
  );
    logic        [MAX_W-1:0] mask_in;
    logic        [MAX_W-1:0] mask_out;
    logic        [MAX_W-1:0] campo;
    logic signed [MAX_W-1:0] sinal;
    logic signed [MAX_W-1:0] byte_s;
    logic        [MAX_W-1:0] r;

    mask_in  = ~({MAX_W{1'b1}} << in_w);
    mask_out = ~({MAX_W{1'b1}} << out_w);
    campo    = imediato & mask_in;

    // Move the sign bit to the MSB, then shift back arithmetically.
    sinal  = campo << (MAX_W - in_w);
    sinal  = sinal >>> (MAX_W - in_w);
    byte_s = campo << (MAX_W - BYTE_W);
    byte_s = byte_s >>> (MAX_W - BYTE_W);

    case (modo)
      MODO_SINAL:    r = sinal;
      MODO_ZERO:     r = campo;
      MODO_SUPERIOR: r = campo << (out_w - in_w);
      default:       r = byte_s;
    endcase
    return r & mask_out;
  endfunction

endpackage

// File: rtl/fila_extensor.sv
// Generic DEPTH x W valid/ready FIFO with occupancy count. Ready/valid are
// registered-state functions only; there is no write-to-read bypass.
module fila_extensor #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         wr_valid_i,
  output logic                         wr_ready_o,
  input  logic [W-1:0]                 wr_dado_i,
  output logic                         rd_valid_o,
  input  logic                         rd_ready_i,
  output logic [W-1:0]                 rd_dado_o,
  output logic [$clog2(DEPTH+1)-1:0]   ocupacao_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] prox(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign wr_ready_o = (cnt_q != CNT_W'(DEPTH));
  assign rd_valid_o = (cnt_q != '0);
  assign push       = wr_valid_i && wr_ready_o;
  assign pop        = rd_valid_o && rd_ready_i;
  assign rd_dado_o  = mem_q[rd_ptr_q];
  assign ocupacao_o = cnt_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = prox(wr_ptr_q);
    if (pop)  rd_ptr_d = prox(rd_ptr_q);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is cleared on reset so the empty-FIFO head reads as zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= wr_dado_i;
    end
  end

endmodule

// File: rtl/extensor_parametrizado.sv
// Buffered immediate extender: extends imediato per modo at push time and
// queues the OUT_W-bit result between decode and the ALU-operand mux.
module extensor_parametrizado
  import extensor_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            imediato,
  input  logic [1:0]                 modo,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           extensor_out,
  output logic [$clog2(DEPTH+1)-1:0] ocupacao
);

  if (IN_W < BYTE_W) begin : g_err_in_w_min
    $error("extensor_parametrizado: IN_W must be >= 8");
  end
  if (IN_W > OUT_W) begin : g_err_in_w_max
    $error("extensor_parametrizado: IN_W must be <= OUT_W");
  end
  if (OUT_W > MAX_W) begin : g_err_out_w
    $error("extensor_parametrizado: OUT_W exceeds extensor_pkg::MAX_W");
  end
  if (DEPTH < 1) begin : g_err_depth
    $error("extensor_parametrizado: DEPTH must be >= 1");
  end

  logic [MAX_W-1:0] ext_full;
  logic [OUT_W-1:0] ext_dado;
  logic             unused_ext;

  assign ext_full = estender(MAX_W'(imediato), modo_t'(modo), IN_W, OUT_W);
  assign ext_dado = ext_full[OUT_W-1:0];
  // Bits above OUT_W are zero by construction of estender().
  assign unused_ext = ^ext_full;

  fila_extensor #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fila (
    .clock      (clock),
    .reset_n    (reset_n),
    .wr_valid_i (in_valid),
    .wr_ready_o (in_ready),
    .wr_dado_i  (ext_dado),
    .rd_valid_o (out_valid),
    .rd_ready_i (out_ready),
    .rd_dado_o  (extensor_out),
    .ocupacao_o (ocupacao)
  );

endmodule
